// File: rtl/lcd_cmd_sched.sv
// Host command queue in front of lcd_ctrl: issues one command at a time, streams 36-byte images for LOAD.
// Optional watchdog on ISSUE/WAIT_OUT is built in when LCD_SCHED_TIMEOUT_EN is defined.
module lcd_cmd_sched #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMG_W      = 2,
  parameter int          ADDR_W     = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        host_cmd,
  input  logic [IMG_W-1:0]  host_sel,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [2:0]        lcd_cmd,
  output logic              lcd_cmd_valid,
  input  logic              lcd_busy,
  output logic [7:0]        lcd_datain,
  input  logic              lcd_output_valid,
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_data,
  output logic              done,
  output logic              err
);

  // state    | meaning
  // IDLE     | pop next queued command, drop invalid ones with err
  // ISSUE    | lcd_cmd_valid held until lcd_busy is low
  // STREAM   | forward 36 image bytes from image memory
  // WAIT_OUT | count 9 output pixels, then done
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_WAIT_OUT} state_t;

  localparam int         PW        = $clog2(FIFO_DEPTH);
  localparam logic [2:0] CMD_LOAD  = 3'd1;
  localparam logic [5:0] IMG_BYTES = 6'd36;
  localparam logic [3:0] LAST_PIX  = 4'd8;

  logic [2:0]       fifo_cmd [FIFO_DEPTH];
  logic [IMG_W-1:0] fifo_sel [FIFO_DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_full, fifo_empty, push, pop;
  logic [2:0]       head_cmd;
  logic [IMG_W-1:0] head_sel;
  logic [ADDR_W-1:0] head_base;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              loaded_q, loaded_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [3:0]        pix_q, pix_d;
  logic [2:0]        lcd_cmd_q, lcd_cmd_d;
  logic              lcd_cmd_valid_q, lcd_cmd_valid_d;
  logic              done_q, done_d, err_q, err_d;
  logic              load_accept, stream_rd;

`ifdef LCD_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign host_ready = !fifo_full;
  assign push       = host_valid && !fifo_full;
  assign head_cmd   = fifo_cmd[rd_ptr_q[PW-1:0]];
  assign head_sel   = fifo_sel[rd_ptr_q[PW-1:0]];
  // sel*36 without a multiplier
  assign head_base  = (ADDR_W'(head_sel) << 5) + (ADDR_W'(head_sel) << 2);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd[wr_ptr_q[PW-1:0]] <= host_cmd;
      fifo_sel[wr_ptr_q[PW-1:0]] <= host_sel;
    end
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    loaded_d        = loaded_q;
    cnt_d           = cnt_q;
    pix_d           = pix_q;
    lcd_cmd_d       = lcd_cmd_q;
    lcd_cmd_valid_d = lcd_cmd_valid_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    pop             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_cmd[2:1] == 2'b11 || (head_cmd != CMD_LOAD && !loaded_q)) begin
            err_d = 1'b1;
          end else begin
            lcd_cmd_d       = head_cmd;
            lcd_cmd_valid_d = 1'b1;
            base_d          = head_base;
            state_d         = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!lcd_busy) begin
          lcd_cmd_valid_d = 1'b0;
          if (lcd_cmd_q == CMD_LOAD) begin
            cnt_d    = 6'd1;
            loaded_d = 1'b1;
            state_d  = S_STREAM;
          end else begin
            pix_d   = 4'd0;
            state_d = S_WAIT_OUT;
          end
        end
      end
      S_STREAM: begin
        if (cnt_q == IMG_BYTES) begin
          pix_d   = 4'd0;
          state_d = S_WAIT_OUT;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_WAIT_OUT: begin
        if (lcd_output_valid) begin
          if (pix_q == LAST_PIX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pix_d = pix_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef LCD_SCHED_TIMEOUT_EN
    // down-counter reloads on every state change; terminal count aborts the command
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = WD_W'(TIMEOUT - 1);
    end else if (state_q == S_ISSUE || state_q == S_WAIT_OUT) begin
      if (wd_q == '0) begin
        err_d           = 1'b1;
        lcd_cmd_valid_d = 1'b0;
        state_d         = S_IDLE;
      end else begin
        wd_d = wd_q - WD_W'(1);
      end
    end
`endif
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
  end

`ifndef LCD_SCHED_TIMEOUT_EN
  // TIMEOUT has no effect without the watchdog
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      base_q          <= '0;
      loaded_q        <= 1'b0;
      cnt_q           <= '0;
      pix_q           <= '0;
      lcd_cmd_q       <= '0;
      lcd_cmd_valid_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
      wd_q            <= '0;
`endif
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      base_q          <= base_d;
      loaded_q        <= loaded_d;
      cnt_q           <= cnt_d;
      pix_q           <= pix_d;
      lcd_cmd_q       <= lcd_cmd_d;
      lcd_cmd_valid_q <= lcd_cmd_valid_d;
      done_q          <= done_d;
      err_q           <= err_d;
`ifdef LCD_SCHED_TIMEOUT_EN
      wd_q            <= wd_d;
`endif
    end
  end

  // memory read for byte 0 is issued in the accept cycle itself, so it depends on lcd_busy
  assign load_accept   = (state_q == S_ISSUE) && (lcd_cmd_q == CMD_LOAD) && !lcd_busy;
  assign stream_rd     = (state_q == S_STREAM) && (cnt_q < IMG_BYTES);
  assign img_rd        = load_accept || stream_rd;
  assign img_addr      = stream_rd ? base_q + ADDR_W'(cnt_q) : (load_accept ? base_q : '0);
  assign lcd_datain    = (state_q == S_STREAM) ? img_data : 8'd0;
  assign lcd_cmd       = lcd_cmd_q;
  assign lcd_cmd_valid = lcd_cmd_valid_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
